// File: rtl/ufpu_policy_seq.sv
// ufpu_policy_seq: runs one ufpu through a short stored program, feeding
// each stage's output vector back in as the next stage's input.
//
// Optional build macro:
//   UFPU_POLICY_SEQ_EARLY_EXIT_EN - finish the run as soon as a stage
//                                   returns an all-zero vector.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   cfg_we/cfg_addr    - write program slot (only honoured while idle)
//   cfg_opcode..pred_op- slot contents
//   cfg_num_stages     - program length, latched on start
//   start, init_vec    - begin a run with this candidate vector
//   busy               - run in progress
//   result_valid/_vec  - one-cycle pulse with final vector (vec held)
//   error              - sticky ufpu timeout, cleared by next start
//   u_*                - ufpu request fields and response
module ufpu_policy_seq #(
    parameter int BIT_VEC_SIZE       = 64,
    parameter int BIT_VEC_SIZE_LOG   = 6,
    parameter int NUM_OF_METRICS_LOG = 2,
    parameter int MAX_STAGES         = 8,
    parameter int STAGE_LOG          = 3,
    parameter int TIMEOUT            = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [STAGE_LOG-1:0]          cfg_addr,
    input  logic [2:0]                    cfg_opcode,
    input  logic [BIT_VEC_SIZE_LOG-1:0]   cfg_id,
    input  logic [NUM_OF_METRICS_LOG-1:0] cfg_metricX,
    input  logic [15:0]                   cfg_val,
    input  logic [2:0]                    cfg_pred_op,
    input  logic [STAGE_LOG:0]            cfg_num_stages,
    input  logic                          start,
    input  logic [BIT_VEC_SIZE-1:0]       init_vec,
    output logic                          busy,
    output logic                          result_valid,
    output logic [BIT_VEC_SIZE-1:0]       result_vec,
    output logic                          error,
    output logic [BIT_VEC_SIZE-1:0]       u_in,
    output logic                          u_valid_in,
    output logic [2:0]                    u_opcode,
    output logic [BIT_VEC_SIZE_LOG-1:0]   u_id,
    output logic [NUM_OF_METRICS_LOG-1:0] u_metricX,
    output logic [15:0]                   u_val,
    output logic [2:0]                    u_pred_op,
    input  logic [BIT_VEC_SIZE-1:0]       u_out,
    input  logic                          u_valid_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
    localparam logic [STAGE_LOG:0] MAX_N = (STAGE_LOG + 1)'(MAX_STAGES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [2:0]                    opcode;
        logic [BIT_VEC_SIZE_LOG-1:0]   id;
        logic [NUM_OF_METRICS_LOG-1:0] metric;
        logic [15:0]                   val;
        logic [2:0]                    pred_op;
    } slot_t;

    slot_t prog [MAX_STAGES];

    state_t                  state, state_d;
    logic [BIT_VEC_SIZE-1:0] cur_vec, cur_vec_d;
    logic [STAGE_LOG:0]      n_stages, n_stages_d;
    logic [STAGE_LOG:0]      stage, stage_d;
    logic [STAGE_LOG:0]      stage_inc;
    logic [CNT_W-1:0]        wcnt, wcnt_d;
    logic [CNT_W-1:0]        wcnt_inc;
    logic                    busy_d;
    logic                    error_d;
    logic                    result_valid_d;
    logic [BIT_VEC_SIZE-1:0] result_vec_d;
    logic                    u_valid_in_d;
    logic [BIT_VEC_SIZE-1:0] u_in_d;
    slot_t                   u_slot, u_slot_d;
    slot_t                   nxt_slot;
    logic                    early_stop;
    logic [STAGE_LOG:0]      n_sat;

`ifdef UFPU_POLICY_SEQ_EARLY_EXIT_EN
    // One-hot selecting opcodes yield zero when nothing qualifies,
    // so later stages cannot bring a candidate back.
    assign early_stop = (u_out == '0);
`else
    assign early_stop = 1'b0;
`endif

    assign stage_inc = stage + 1'b1;
    assign wcnt_inc  = wcnt + 1'b1;
    assign n_sat     = (cfg_num_stages > MAX_N) ? MAX_N : cfg_num_stages;

    // Program memory: deliberately not reset; edits only while idle.
    always_ff @(posedge clk) begin
        if (cfg_we && state == S_IDLE) begin
            prog[cfg_addr] <= '{
                opcode:  cfg_opcode,
                id:      cfg_id,
                metric:  cfg_metricX,
                val:     cfg_val,
                pred_op: cfg_pred_op
            };
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cur_vec      <= '0;
            n_stages     <= '0;
            stage        <= '0;
            wcnt         <= '0;
            busy         <= 1'b0;
            error        <= 1'b0;
            result_valid <= 1'b0;
            result_vec   <= '0;
            u_valid_in   <= 1'b0;
            u_in         <= '0;
            u_slot       <= '0;
        end else begin
            state        <= state_d;
            cur_vec      <= cur_vec_d;
            n_stages     <= n_stages_d;
            stage        <= stage_d;
            wcnt         <= wcnt_d;
            busy         <= busy_d;
            error        <= error_d;
            result_valid <= result_valid_d;
            result_vec   <= result_vec_d;
            u_valid_in   <= u_valid_in_d;
            u_in         <= u_in_d;
            u_slot       <= u_slot_d;
        end
    end

    always_comb begin
        state_d        = state;
        cur_vec_d      = cur_vec;
        n_stages_d     = n_stages;
        stage_d        = stage;
        wcnt_d         = wcnt;
        busy_d         = busy;
        error_d        = error;
        result_valid_d = 1'b0;
        result_vec_d   = result_vec;
        u_valid_in_d   = 1'b0;
        u_in_d         = u_in;
        u_slot_d       = u_slot;
        nxt_slot       = prog[stage_inc[STAGE_LOG-1:0]];

        unique case (state)
            S_IDLE: begin
                // The cycle that shows result_valid is still idle;
                // a start there waits one more cycle.
                if (start && !result_valid) begin
                    cur_vec_d  = init_vec;
                    n_stages_d = n_sat;
                    stage_d    = '0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                    if (n_sat == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d      = S_ISSUE;
                        u_valid_in_d = 1'b1;
                        u_in_d       = init_vec;
                        u_slot_d     = prog[0];
                    end
                end
            end
            S_ISSUE: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Request fields stay put: the ufpu reads them late.
                if (u_valid_out) begin
                    cur_vec_d = u_out;
                    stage_d   = stage_inc;
                    if (stage_inc == n_stages || early_stop) begin
                        state_d = S_DONE;
                    end else begin
                        state_d      = S_ISSUE;
                        u_valid_in_d = 1'b1;
                        u_in_d       = u_out;
                        u_slot_d     = nxt_slot;
                    end
                end else if (wcnt_inc == TO_LIM) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wcnt_d = wcnt_inc;
                end
            end
            S_DONE: begin
                result_valid_d = 1'b1;
                result_vec_d   = cur_vec;
                busy_d         = 1'b0;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign u_opcode  = u_slot.opcode;
    assign u_id      = u_slot.id;
    assign u_metricX = u_slot.metric;
    assign u_val     = u_slot.val;
    assign u_pred_op = u_slot.pred_op;

endmodule

// File: tb/tb_ufpu_policy_seq.sv
// Bench for ufpu_policy_seq: small ufpu model (000 pass, 001 keep bit id),
// scoreboard of expected results checked by an independent monitor.
module tb_ufpu_policy_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [2:0]  cfg_opcode;
    logic [5:0]  cfg_id;
    logic [1:0]  cfg_metricX;
    logic [15:0] cfg_val;
    logic [2:0]  cfg_pred_op;
    logic [3:0]  cfg_num_stages;
    logic        start;
    logic [63:0] init_vec;
    logic        busy;
    logic        result_valid;
    logic [63:0] result_vec;
    logic        error;
    logic [63:0] u_in;
    logic        u_valid_in;
    logic [2:0]  u_opcode;
    logic [5:0]  u_id;
    logic [1:0]  u_metricX;
    logic [15:0] u_val;
    logic [2:0]  u_pred_op;
    logic [63:0] u_out;
    logic        u_valid_out;

    ufpu_policy_seq dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_opcode(cfg_opcode), .cfg_id(cfg_id),
        .cfg_metricX(cfg_metricX), .cfg_val(cfg_val),
        .cfg_pred_op(cfg_pred_op),
        .cfg_num_stages(cfg_num_stages),
        .start(start), .init_vec(init_vec),
        .busy(busy), .result_valid(result_valid),
        .result_vec(result_vec), .error(error),
        .u_in(u_in), .u_valid_in(u_valid_in),
        .u_opcode(u_opcode), .u_id(u_id),
        .u_metricX(u_metricX), .u_val(u_val),
        .u_pred_op(u_pred_op),
        .u_out(u_out), .u_valid_out(u_valid_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int vin_cnt = 0;
    logic stall = 1'b0;

    typedef struct {
        logic [63:0] vec;
        int          cyc;
        logic        err;
    } exp_t;
    exp_t q[$];

`ifdef UFPU_POLICY_SEQ_EARLY_EXIT_EN
    localparam int EX_LAT = 4;
`else
    localparam int EX_LAT = 7;
`endif

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && u_valid_in) vin_cnt <= vin_cnt + 1;
    end

    // ufpu model: 2-cycle latency, operation fields read in cycle two
    logic        p_v;
    logic [63:0] p_in;
    always @(posedge clk) begin
        if (rst) begin
            p_v <= 1'b0;
            p_in <= '0;
            u_valid_out <= 1'b0;
            u_out <= '0;
        end else begin
            p_v <= u_valid_in;
            p_in <= u_in;
            u_valid_out <= p_v && !stall;
            if (p_v) begin
                if (u_opcode == 3'b001)
                    u_out <= p_in & (64'd1 << u_id);
                else
                    u_out <= p_in;
            end
        end
    end

    // monitor
    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result_vec", result_vec, e.vec);
                chk("result_cycle", 64'(cyc), 64'(e.cyc));
                chk("error_at_result", {63'd0, error}, {63'd0, e.err});
            end
        end
    end

    task automatic wr(input int a, input logic [2:0] op,
                      input logic [5:0] id);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = a[2:0];
        cfg_opcode = op;
        cfg_id = id;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic run(input logic [3:0] n, input logic [63:0] init,
                       input logic [63:0] exp, input int lat,
                       input logic err);
        int s;
        @(negedge clk);
        start = 1'b1;
        cfg_num_stages = n;
        init_vec = init;
        @(posedge clk);
        #1 start = 1'b0;
        s = cyc;
        q.push_back('{exp, s + lat, err});
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk("busy_run", {63'd0, busy}, 64'd1);
            if (k == 0) chk("error_cleared", {63'd0, error}, 64'd0);
        end
        @(negedge clk);
        chk("busy_after", {63'd0, busy}, 64'd0);
    endtask

    task automatic drain();
        int b = 0;
        while (q.size() != 0 && b < 100) begin
            @(negedge clk);
            b++;
        end
        chk("queue_drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int v0;
        int s;
        rst = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_opcode = '0; cfg_id = '0;
        cfg_metricX = '0; cfg_val = '0; cfg_pred_op = '0;
        cfg_num_stages = '0; start = 1'b0; init_vec = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rv", {63'd0, result_valid}, 64'd0);
        chk("rst_vec", result_vec, 64'd0);
        chk("rst_err", {63'd0, error}, 64'd0);
        chk("rst_vin", {63'd0, u_valid_in}, 64'd0);
        chk("rst_uin", u_in, 64'd0);
        chk("rst_uop", {61'd0, u_opcode}, 64'd0);
        rst = 1'b0;

        // single pass-through stage
        wr(0, 3'b000, 6'd0);
        v0 = vin_cnt;
        run(4'd1, 64'hF0, 64'hF0, 4, 1'b0);
        chk("issue_count_1", 64'(vin_cnt - v0), 64'd1);

        // start in the result_valid cycle waits one cycle
        start = 1'b1; cfg_num_stages = 4'd1; init_vec = 64'h33;
        @(posedge clk);
        #1 chk("start_blocked", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1 start = 1'b0;
        s = cyc;
        chk("start_late", {63'd0, busy}, 64'd1);
        q.push_back('{64'h33, s + 4, 1'b0});
        drain();

        // two stages: keep bit 4, then pass
        wr(0, 3'b001, 6'd4);
        wr(1, 3'b000, 6'd0);
        v0 = vin_cnt;
        run(4'd2, 64'h1F, 64'h10, 7, 1'b0);
        chk("issue_count_2", 64'(vin_cnt - v0), 64'd2);

        // empty program
        v0 = vin_cnt;
        run(4'd0, 64'hABCD, 64'hABCD, 1, 1'b0);
        chk("no_issue_n0", 64'(vin_cnt - v0), 64'd0);

        // ufpu never answers
        wr(0, 3'b000, 6'd0);
        stall = 1'b1;
        run(4'd1, 64'h77, 64'h77, 17, 1'b1);
        chk("err_sticky", {63'd0, error}, 64'd1);
        stall = 1'b0;
        repeat (3) @(negedge clk);
        run(4'd1, 64'h5, 64'h5, 4, 1'b0);

        // zero intermediate result
        wr(0, 3'b001, 6'd3);
        wr(1, 3'b000, 6'd0);
        run(4'd2, 64'h1, 64'h0, EX_LAT, 1'b0);

        // length saturates to 8 stages
        for (int i = 0; i < 7; i++) wr(i, 3'b000, 6'd0);
        wr(7, 3'b001, 6'd1);
        run(4'd15, 64'hFF, 64'h2, 25, 1'b0);

        // reset mid-run, with start and cfg write attempted
        wr(0, 3'b001, 6'd4);
        wr(1, 3'b000, 6'd0);
        wr(2, 3'b000, 6'd0);
        @(negedge clk);
        start = 1'b1; cfg_num_stages = 4'd3; init_vec = 64'h1F;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        start = 1'b1; init_vec = 64'hFFFF;
        cfg_we = 1'b1; cfg_addr = 3'd0;
        cfg_opcode = 3'b001; cfg_id = 6'd0;
        @(posedge clk);
        #1 start = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("busy_after_rst", {63'd0, busy}, 64'd0);
        repeat (12) @(negedge clk);
        chk("no_result_rst", 64'(q.size()), 64'd0);
        run(4'd3, 64'h1F, 64'h10, 10, 1'b0);

        drain();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
